// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - 8-digit multiplexed seven-segment scan driver
// Frame-snapshotted codes, per-slot blank gap, per-digit blinking.
module seg7_scan_driver #(
  parameter int DIGIT_CYCLES = 100000,
  parameter int BLANK_CYCLES = 2000,
  parameter int BLINK_CYCLES = 25000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] d1,
  input  logic [5:0] d2,
  input  logic [5:0] d3,
  input  logic [5:0] d4,
  input  logic [5:0] d5,
  input  logic [5:0] d6,
  input  logic [5:0] d7,
  input  logic [5:0] d8,
  input  logic [7:0] blink_mask,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       frame_start
);

  localparam int SW = $clog2(DIGIT_CYCLES);
  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  logic [SW-1:0] slot_cnt_q, slot_cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_phase_q, blink_phase_d;
  logic [5:0]    shadow_q [8];
  logic [5:0]    shadow_d [8];
  logic [7:0]    shadow_blink_q, shadow_blink_d;
  logic [7:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          frame_start_q, frame_start_d;

  logic          slot_wrap;
  logic          blink_wrap;
  logic          snap;
  logic [5:0]    cur_code;
  logic          cur_blink;

  // Active-low {g,f,e,d,c,b,a}
  function automatic logic [6:0] glyph(input logic [4:0] g);
    case (g)
      5'd0:  glyph = 7'h40;
      5'd1:  glyph = 7'h79;
      5'd2:  glyph = 7'h24;
      5'd3:  glyph = 7'h30;
      5'd4:  glyph = 7'h19;
      5'd5:  glyph = 7'h12;
      5'd6:  glyph = 7'h02;
      5'd7:  glyph = 7'h78;
      5'd8:  glyph = 7'h00;
      5'd9:  glyph = 7'h10;
      5'd10: glyph = 7'h08;
      5'd11: glyph = 7'h03;
      5'd12: glyph = 7'h46;
      5'd13: glyph = 7'h21;
      5'd14: glyph = 7'h06;
      5'd15: glyph = 7'h0E;
      5'd16: glyph = 7'h42;
      5'd17: glyph = 7'h09;
      5'd18: glyph = 7'h79;
      5'd19: glyph = 7'h61;
      5'd20: glyph = 7'h47;
      5'd21: glyph = 7'h2B;
      5'd22: glyph = 7'h23;
      5'd23: glyph = 7'h0C;
      5'd24: glyph = 7'h2F;
      5'd25: glyph = 7'h07;
      5'd26: glyph = 7'h41;
      5'd27: glyph = 7'h11;
      5'd28: glyph = 7'h3F;
      5'd29: glyph = 7'h77;
      5'd30: glyph = 7'h37;
      default: glyph = 7'h7F;
    endcase
  endfunction

  always_comb begin
    slot_wrap     = (slot_cnt_q == SW'(DIGIT_CYCLES - 1));
    slot_cnt_d    = slot_wrap ? '0 : slot_cnt_q + SW'(1);
    idx_d         = slot_wrap ? idx_q + 3'd1 : idx_q;
    blink_wrap    = (blink_cnt_q == BW'(BLINK_CYCLES - 1));
    blink_cnt_d   = blink_wrap ? '0 : blink_cnt_q + BW'(1);
    blink_phase_d = blink_phase_q ^ blink_wrap;

    snap           = (slot_cnt_q == '0) && (idx_q == 3'd0);
    frame_start_d  = snap;
    shadow_d       = shadow_q;
    shadow_blink_d = shadow_blink_q;
    if (snap) begin
      shadow_d       = '{d1, d2, d3, d4, d5, d6, d7, d8};
      shadow_blink_d = blink_mask;
    end

    // Slot 0 is always inside the blank gap, so the pre-snapshot shadow is never shown.
    cur_code  = shadow_q[idx_q];
    cur_blink = shadow_blink_q[3'd7 - idx_q];
    an_d      = 8'hFF;
    seg_d     = 7'h7F;
    if (slot_cnt_q >= SW'(BLANK_CYCLES)) begin
      an_d = ~(8'h80 >> idx_q);
      if (cur_code[0] && !(cur_blink && blink_phase_q)) begin
        seg_d = glyph(cur_code[5:1]);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      slot_cnt_q     <= '0;
      idx_q          <= 3'd0;
      blink_cnt_q    <= '0;
      blink_phase_q  <= 1'b0;
      shadow_q       <= '{default: 6'd0};
      shadow_blink_q <= 8'h00;
      an_q           <= 8'hFF;
      seg_q          <= 7'h7F;
      frame_start_q  <= 1'b0;
    end else begin
      slot_cnt_q     <= slot_cnt_d;
      idx_q          <= idx_d;
      blink_cnt_q    <= blink_cnt_d;
      blink_phase_q  <= blink_phase_d;
      shadow_q       <= shadow_d;
      shadow_blink_q <= shadow_blink_d;
      an_q           <= an_d;
      seg_q          <= seg_d;
      frame_start_q  <= frame_start_d;
    end
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - randomized bench with cycle-count reference model
// Model derives counters from cycles elapsed since reset release.
module tb_seg7_scan_driver;
  localparam int DC = 4;
  localparam int BK = 1;
  localparam int BL = 16;
  localparam int FRAME = 8 * DC;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] din [8];
  logic [7:0] blink_mask = 8'h00;
  logic [7:0] an;
  logic [6:0] seg;
  logic       frame_start;

  int checks = 0;
  int failures = 0;

  logic [6:0] gt [32] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E,
                          7'h42, 7'h09, 7'h79, 7'h61, 7'h47, 7'h2B, 7'h23, 7'h0C,
                          7'h2F, 7'h07, 7'h41, 7'h11, 7'h3F, 7'h77, 7'h37, 7'h7F};

  int         n_model = 0;
  logic [5:0] m_sh [8];
  logic [7:0] m_bm = 8'h00;
  logic [7:0] exp_an = 8'hFF;
  logic [6:0] exp_seg = 7'h7F;
  logic       exp_fs = 1'b0;
  logic       model_started = 1'b0;

  seg7_scan_driver #(.DIGIT_CYCLES(DC), .BLANK_CYCLES(BK), .BLINK_CYCLES(BL)) dut (
    .clock(clock), .reset(reset),
    .d1(din[0]), .d2(din[1]), .d3(din[2]), .d4(din[3]),
    .d5(din[4]), .d6(din[5]), .d7(din[6]), .d8(din[7]),
    .blink_mask(blink_mask), .an(an), .seg(seg), .frame_start(frame_start)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at t=%0t", nm, act, expv, $time);
    end
  endtask

  // Reference: counter state at the n-th edge after release is pure arithmetic on n.
  always @(posedge clock) begin
    model_started = 1'b1;
    if (reset) begin
      n_model = 0;
      exp_an  = 8'hFF;
      exp_seg = 7'h7F;
      exp_fs  = 1'b0;
      m_bm    = 8'h00;
      for (int i = 0; i < 8; i++) m_sh[i] = 6'd0;
    end else begin
      int slot, idx, ph;
      slot   = n_model % DC;
      idx    = (n_model / DC) % 8;
      ph     = (n_model / BL) % 2;
      exp_fs = (n_model % FRAME) == 0;
      exp_an  = 8'hFF;
      exp_seg = 7'h7F;
      if (slot >= BK) begin
        exp_an = 8'hFF;
        exp_an[7 - idx] = 1'b0;
        if (m_sh[idx][0] && !(m_bm[7 - idx] && ph == 1)) exp_seg = gt[m_sh[idx][5:1]];
      end
      if (exp_fs) begin
        for (int i = 0; i < 8; i++) m_sh[i] = din[i];
        m_bm = blink_mask;
      end
      n_model++;
    end
  end

  always @(negedge clock) begin
    if (model_started) begin
      chk("an_model", an, exp_an);
      chk("seg_model", {1'b0, seg}, {1'b0, exp_seg});
      chk("fs_model", {7'd0, frame_start}, {7'd0, exp_fs});
      chk("an_onehot", {7'd0, ($countones(~an) <= 1)}, 8'd1);
    end
  end

  task automatic step(input int k);
    repeat (k) @(negedge clock);
  endtask

  task automatic wait_fs();
    int k;
    logic found;
    found = 1'b0;
    k = 0;
    while (k < 3 * FRAME && !found) begin
      @(negedge clock);
      found = frame_start;
      k++;
    end
    chk("fs_timeout", {7'd0, found}, 8'd1);
  endtask

  task automatic lit(input string nm, input logic [7:0] ea, input logic [6:0] es);
    chk({nm, "_an"}, an, ea);
    chk({nm, "_seg"}, {1'b0, seg}, {1'b0, es});
  endtask

  initial begin
    din[0] = 6'b000001;
    for (int i = 1; i < 8; i++) din[i] = 6'b111111;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      lit("in_reset", 8'hFF, 7'h7F);
      chk("in_reset_fs", {7'd0, frame_start}, 8'd0);
    end
    reset = 1'b0;
    step(1);
    chk("first_fs", {7'd0, frame_start}, 8'd1);
    lit("first_blank", 8'hFF, 7'h7F);
    step(1);
    lit("d1_zero", 8'h7F, 7'h40);
    step(3);
    lit("gap1", 8'hFF, 7'h7F);
    step(1);
    lit("d2_blank_glyph", 8'hBF, 7'h7F);
    step(30);

    din = '{{5'd8, 1'b1}, {5'd14, 1'b1}, {5'd28, 1'b1}, {5'd29, 1'b1},
            6'd1, 6'd1, 6'd1, 6'd1};
    wait_fs();
    step(1);  lit("walk_d1", 8'h7F, 7'h00);
    step(4);  lit("walk_d2", 8'hBF, 7'h06);
    step(4);  lit("walk_d3", 8'hDF, 7'h3F);
    step(4);  lit("walk_d4", 8'hEF, 7'h77);
    step(4);  lit("walk_d5", 8'hF7, 7'h40);

    wait_fs();
    step(10);
    din[2] = 6'b000001;
    step(1);  lit("d3_old", 8'hDF, 7'h3F);
    wait_fs();
    step(9);  lit("d3_new", 8'hDF, 7'h40);

    for (int i = 0; i < 8; i++) din[i] = 6'b000001;
    blink_mask = 8'h88;
    wait_fs();
    wait_fs();
    step(1);  lit("blink_d1_ph0", 8'h7F, 7'h40);
    step(16); lit("blink_d5_ph1", 8'hF7, 7'h7F);
    step(4);  lit("noblink_d6", 8'hFB, 7'h40);

    for (int c = 0; c < 16 * FRAME; c++) begin
      if ($urandom_range(0, 7) == 0) din[$urandom_range(0, 7)] = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 31) == 0) blink_mask = 8'($urandom);
      step(1);
    end

    wait_fs();
    step(21);
    reset = 1'b1;
    step(1);
    lit("midreset", 8'hFF, 7'h7F);
    step(1);
    reset = 1'b0;
    din[0] = {5'd8, 1'b1};
    step(1);
    chk("restart_fs", {7'd0, frame_start}, 8'd1);
    step(1);
    lit("restart_d1", 8'h7F, 7'h00);
    step(2 * FRAME);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
